cpu_tstate_gen: RTL and testbench

Generates the 6502 instruction-cycle timing state, T0..T(MAX_T), as a 3-bit binary index.
The parent feeds this index into the existing 3-bit one-hot decoder to produce per-cycle strobes for the control logic.
Handles the post-reset boot sequence, RDY stalls and end-of-instruction restart.
Flags a timing error if an instruction runs past MAX_T.

---
 rtl/cpu_timing_pkg.sv | 15 +
 rtl/cpu_tstate_dec.sv | 10 +
 rtl/cpu_tstate_gen.sv | 81 ++++++++
 tb/tb_cpu_tstate_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_timing_pkg.sv
// Shared timing definitions for the 6502 T-state generator: controller modes,
// index width and default instruction-timing limits.
package cpu_timing_pkg;

    localparam int TSTATE_W        = 3;
    localparam int MAX_T_DEF       = 6;
    localparam int BOOT_CYCLES_DEF = 7;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } tgen_state_e;

endpackage

// File: rtl/cpu_tstate_dec.sv
// 3-bit binary to one-hot decoder turning the T-state index into per-cycle
// control strobes.
module cpu_tstate_dec (
    input  logic [2:0] tstate,
    output logic [7:0] strobe
);

    assign strobe = 8'd1 << tstate;

endmodule

// File: rtl/cpu_tstate_gen.sv
// 6502 instruction-cycle timing generator: boot delay after reset, T0..MAX_T
// sequencing with RDY stall, end-of-instruction restart and overrun trap.
module cpu_tstate_gen
    import cpu_timing_pkg::*;
#(
    parameter int MAX_T       = MAX_T_DEF,
    parameter int BOOT_CYCLES = BOOT_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                t_reset,
    output logic [TSTATE_W-1:0] tstate,
    output logic                sync,
    output logic                boot,
    output logic                t_err
);

    localparam logic [TSTATE_W-1:0] T_LAST    = TSTATE_W'(MAX_T);
    localparam logic [3:0]          BOOT_LAST = 4'(BOOT_CYCLES - 1);

    tgen_state_e         state_q, state_d;
    logic [TSTATE_W-1:0] tstate_q, tstate_d;
    logic [3:0]          boot_cnt_q, boot_cnt_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d    = state_q;
        tstate_d   = tstate_q;
        boot_cnt_d = boot_cnt_q;

        if (rdy) begin
            case (state_q)
                ST_BOOT: begin
                    tstate_d = '0;
                    if (boot_cnt_q == BOOT_LAST) begin
                        state_d    = ST_RUN;
                        boot_cnt_d = '0;
                    end else begin
                        boot_cnt_d = boot_cnt_q + 4'd1;
                    end
                end
                ST_RUN: begin
                    // Overrun traps instead of incrementing, so 7 never wraps to 0.
                    if (t_reset) begin
                        tstate_d = '0;
                    end else if (tstate_q == T_LAST) begin
                        state_d = ST_HALT;
                    end else begin
                        tstate_d = tstate_q + 1'b1;
                    end
                end
                ST_HALT: ;
                default: begin
                    state_d    = ST_BOOT;
                    tstate_d   = '0;
                    boot_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            state_q    <= ST_BOOT;
            tstate_q   <= '0;
            boot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tstate_q   <= tstate_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    assign tstate = tstate_q;
    assign sync   = (state_q == ST_RUN) && (tstate_q == '0);
    assign boot   = (state_q == ST_BOOT);
    assign t_err  = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_tstate_gen.sv
// Bench for cpu_tstate_gen: a directed vector table, hand sequences for the
// MAX_T=7/BOOT_CYCLES=1 build, and random traffic checked against a model.
module tb_cpu_tstate_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rdy = 1'b1;
    logic       t_reset = 1'b0;

    logic [2:0] tstate_a, tstate_b;
    logic       sync_a, sync_b, boot_a, boot_b, err_a, err_b;
    logic [7:0] strobe_a, strobe_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_tstate_gen u_dut_a (
        .clk(clk), .rst(rst), .rdy(rdy), .t_reset(t_reset),
        .tstate(tstate_a), .sync(sync_a), .boot(boot_a), .t_err(err_a)
    );

    cpu_tstate_gen #(.MAX_T(7), .BOOT_CYCLES(1)) u_dut_b (
        .clk(clk), .rst(rst), .rdy(rdy), .t_reset(t_reset),
        .tstate(tstate_b), .sync(sync_b), .boot(boot_b), .t_err(err_b)
    );

    cpu_tstate_dec u_dec_a (.tstate(tstate_a), .strobe(strobe_a));
    cpu_tstate_dec u_dec_b (.tstate(tstate_b), .strobe(strobe_b));

    // Model: boot is a countdown of remaining rdy cycles, then an instruction
    // cycle counter that latches an error once it would pass the limit.
    typedef struct {
        int boot_left;
        int t;
        bit halted;
    } model_t;

    model_t ma, mb;

    function automatic model_t mstep(model_t m, bit r, bit ry, bit tr,
                                     int max_t, int boot_cycles);
        model_t n = m;
        if (r) begin
            n.boot_left = boot_cycles;
            n.t         = 0;
            n.halted    = 1'b0;
        end else if (ry) begin
            if (m.boot_left > 0)  n.boot_left = m.boot_left - 1;
            else if (m.halted)    n = m;
            else if (tr)          n.t = 0;
            else if (m.t == max_t) n.halted = 1'b1;
            else                  n.t = m.t + 1;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_models();
        bit mb_boot, ma_boot;
        ma_boot = (ma.boot_left > 0);
        mb_boot = (mb.boot_left > 0);
        check("a_tstate", 32'(tstate_a), 32'(ma.t));
        check("a_sync",   32'(sync_a),   32'(!ma_boot && !ma.halted && ma.t == 0));
        check("a_boot",   32'(boot_a),   32'(ma_boot));
        check("a_err",    32'(err_a),    32'(ma.halted));
        check("a_strobe", 32'(strobe_a), 32'(1 << ma.t));
        check("b_tstate", 32'(tstate_b), 32'(mb.t));
        check("b_sync",   32'(sync_b),   32'(!mb_boot && !mb.halted && mb.t == 0));
        check("b_boot",   32'(boot_b),   32'(mb_boot));
        check("b_err",    32'(err_b),    32'(mb.halted));
        check("b_strobe", 32'(strobe_b), 32'(1 << mb.t));
    endtask

    task automatic tick(input bit r, input bit ry, input bit tr);
        @(negedge clk);
        rst     = r;
        rdy     = ry;
        t_reset = tr;
        @(posedge clk);
        ma = mstep(ma, r, ry, tr, 6, 7);
        mb = mstep(mb, r, ry, tr, 7, 1);
        #1;
        check_models();
    endtask

    typedef struct {
        bit       rst;
        bit       rdy;
        bit       t_reset;
        int       ts;
        bit       sync;
        bit       boot;
        bit       err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit ry, bit tr, int ts, bit sy, bit bo, bit er);
        vec_t v;
        v.rst = r; v.rdy = ry; v.t_reset = tr;
        v.ts = ts; v.sync = sy; v.boot = bo; v.err = er;
        vecs.push_back(v);
    endfunction

    function automatic void add_boot_to_t0();
        for (int i = 0; i < 6; i++) add(0, 1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 1, 0, 0);
    endfunction

    initial begin
        ma = '{boot_left: 0, t: 0, halted: 1'b0};
        mb = '{boot_left: 0, t: 0, halted: 1'b0};

        // Reset, then seven boot cycles before the first T0.
        add(1, 1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0, 0, 1, 0);
        add_boot_to_t0();
        // Restart pulsed in T2.
        add(0, 1, 0, 1, 0, 0, 0);
        add(0, 1, 0, 2, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0);
        // Stall at T3 with t_reset high; the pulse must not be queued.
        add(0, 1, 0, 2, 0, 0, 0);
        add(0, 1, 0, 3, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 3, 0, 0, 0);
        add(0, 1, 0, 4, 0, 0, 0);
        // Full run T0..T6 then overrun into HALT, stalls and rst recovery.
        add(0, 1, 1, 0, 1, 0, 0);
        for (int t = 1; t <= 6; t++) add(0, 1, 0, t, 0, 0, 0);
        add(0, 1, 0, 6, 0, 0, 1);
        add(0, 1, 1, 6, 0, 0, 1);
        add(0, 0, 0, 6, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1, 0);
        // Boot again, then t_reset held: back-to-back T0s.
        add_boot_to_t0();
        for (int i = 0; i < 4; i++) add(0, 1, 1, 0, 1, 0, 0);
        // rst in the middle of an instruction at T5.
        for (int t = 1; t <= 5; t++) add(0, 1, 0, t, 0, 0, 0);
        add(1, 1, 1, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0, 1, 0);

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].rdy, vecs[i].t_reset);
            check($sformatf("vec%0d_tstate", i), 32'(tstate_a), 32'(vecs[i].ts));
            check($sformatf("vec%0d_sync", i),   32'(sync_a),   32'(vecs[i].sync));
            check($sformatf("vec%0d_boot", i),   32'(boot_a),   32'(vecs[i].boot));
            check($sformatf("vec%0d_err", i),    32'(err_a),    32'(vecs[i].err));
        end

        // MAX_T=7, BOOT_CYCLES=1: sync one cycle after rst, HALT at 7, no wrap.
        tick(1, 1, 0);
        check("b_rst_boot", 32'(boot_b), 32'd1);
        check("b_rst_sync", 32'(sync_b), 32'd0);
        tick(0, 1, 0);
        check("b_first_sync", 32'(sync_b), 32'd1);
        check("b_first_ts", 32'(tstate_b), 32'd0);
        for (int t = 1; t <= 7; t++) begin
            tick(0, 1, 0);
            check("b_run_ts", 32'(tstate_b), 32'(t));
            check("b_run_err", 32'(err_b), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0);
            check("b_halt_ts", 32'(tstate_b), 32'd7);
            check("b_halt_err", 32'(err_b), 32'd1);
            check("b_halt_sync", 32'(sync_b), 32'd0);
        end
        tick(1, 1, 0);
        check("b_halt_rst_err", 32'(err_b), 32'd0);
        check("b_halt_rst_boot", 32'(boot_b), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom % 50) == 0, ($urandom % 4) != 0, ($urandom % 6) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
